// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter and its LSU result buffer.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous LSU result FIFO; the head entry is visible combinationally so the
// arbiter can write it in the same cycle it decides to pop.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, buffered LSU results
// drain in the gaps, and a busy scoreboard stalls decode. Define WB_BYPASS_EN for bypass ports.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  stall,
    output logic                  alu_hold,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       write_data
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_rs1_hit,
    output logic                  byp_rs2_hit,
    output logic [XLEN-1:0]       byp_data
`endif
);

    wb_entry_t   lsu_entry, head;
    logic        full, empty, push, pop, pop_wr;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  starve_q, starve_d;
    logic        alu_hold_q, alu_hold_d;
    logic        rs1_busy, rs2_busy, rd_busy;

    // LSU handshake: a result transfers on lsu_valid && lsu_ready; the producer
    // keeps lsu_valid and its payload stable until that happens.
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
    assign lsu_ready = !full;
    assign push      = lsu_valid && !full;
    assign pop       = !alu_valid && !empty;
    assign pop_wr    = pop && (head.rd != '0);
    assign alu_hold  = alu_hold_q;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (lsu_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        reg_write  = 1'b0;
        rd_addr    = '0;
        write_data = '0;
        if (alu_valid) begin
            reg_write  = (alu_rd != '0);
            rd_addr    = alu_rd;
            write_data = alu_data;
        end else if (!empty) begin
            reg_write  = (head.rd != '0);
            rd_addr    = head.rd;
            write_data = head.data;
        end
        if (rst) reg_write = 1'b0;
    end

    assign rs1_busy = (dec_rs1 != '0) && busy_q[dec_rs1];
    assign rs2_busy = (dec_rs2 != '0) && busy_q[dec_rs2];
    assign rd_busy  = (dec_rd  != '0) && busy_q[dec_rd];

`ifdef WB_BYPASS_EN
    // A source being written by this cycle's pop is forwarded instead of stalling.
    assign byp_rs1_hit = !rst && pop_wr && (head.rd == dec_rs1);
    assign byp_rs2_hit = !rst && pop_wr && (head.rd == dec_rs2);
    assign byp_data    = write_data;
    assign stall = !rst && ((rs1_busy && !byp_rs1_hit) || (rs2_busy && !byp_rs2_hit) || rd_busy);
`else
    assign stall = !rst && (rs1_busy || rs2_busy || rd_busy);
`endif

    always_comb begin
        busy_d = busy_q;
        if (pop_wr) busy_d[head.rd] = 1'b0;
        // A new issue to the same rd overrides the clear from the pop.
        if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;

        starve_d = starve_q;
        if (pop || empty)           starve_d = '0;
        else if (starve_q != 4'hF)  starve_d = starve_q + 4'd1;

        alu_hold_d = alu_hold_q;
        if (pop)                              alu_hold_d = 1'b0;
        else if (starve_d >= 4'(STARVE_MAX))  alu_hold_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            starve_q   <= '0;
            alu_hold_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            alu_hold_q <= alu_hold_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model, directed scenarios with
// literal expectations, then constrained-random traffic.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic        lsu_ready, stall, alu_hold, reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
`ifdef WB_BYPASS_EN
    logic        byp_rs1_hit, byp_rs2_hit;
    logic [31:0] byp_data;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .stall(stall), .alu_hold(alu_hold),
        .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data)
`ifdef WB_BYPASS_EN
        , .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit), .byp_data(byp_data)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: buffered LSU results as {rd, data}, busy set, starvation.
    logic [36:0] exp_q[$];
    logic [31:0] busy_m = '0;
    int          starve_m = 0;
    bit          hold_m = 1'b0;
    bit          lsu_acc = 1'b0;
    logic [4:0]  pend_q[$];
    logic [4:0]  log_rd[$];
    logic [31:0] log_data[$];
    bit          log_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            busy_m   = '0;
            starve_m = 0;
            hold_m   = 1'b0;
            lsu_acc  = 1'b0;
        end else begin
            bit          was_empty, pop_e;
            logic [36:0] h;
            was_empty = (exp_q.size() == 0);
            pop_e     = !alu_valid && !was_empty;
            lsu_acc   = lsu_valid && (exp_q.size() < DEPTH);
            if (pop_e) begin
                h = exp_q.pop_front();
                if (h[36:32] != 5'd0) busy_m[h[36:32]] = 1'b0;
            end
            if (lsu_acc) exp_q.push_back({lsu_rd, lsu_data});
            if (issue_valid && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
            if (pop_e || was_empty) starve_m = 0;
            else if (starve_m < 15) starve_m = starve_m + 1;
            if (pop_e) hold_m = 1'b0;
            else if (starve_m >= SMAX) hold_m = 1'b1;
        end
    end

    // Compare process: every output against the model, every cycle.
    bit          we_e, st_e, pop_c, h1, h2;
    logic [4:0]  a_e;
    logic [31:0] d_e;
    always @(negedge clk) begin
        we_e = 1'b0; a_e = '0; d_e = '0; pop_c = 1'b0;
        if (alu_valid) begin
            we_e = (alu_rd != 5'd0); a_e = alu_rd; d_e = alu_data;
        end else if (exp_q.size() > 0) begin
            we_e = (exp_q[0][36:32] != 5'd0); a_e = exp_q[0][36:32]; d_e = exp_q[0][31:0];
            pop_c = 1'b1;
        end
        if (rst) we_e = 1'b0;
        h1 = pop_c && we_e && (a_e == dec_rs1);
        h2 = pop_c && we_e && (a_e == dec_rs2);
`ifdef WB_BYPASS_EN
        st_e = !rst && ((dec_rs1 != 0 && busy_m[dec_rs1] && !h1) ||
                        (dec_rs2 != 0 && busy_m[dec_rs2] && !h2) ||
                        (dec_rd != 0 && busy_m[dec_rd]));
        chk("byp_rs1_hit", 32'(byp_rs1_hit), 32'(h1));
        chk("byp_rs2_hit", 32'(byp_rs2_hit), 32'(h2));
        if (h1 || h2) chk("byp_data", byp_data, d_e);
`else
        st_e = !rst && ((dec_rs1 != 0 && busy_m[dec_rs1]) ||
                        (dec_rs2 != 0 && busy_m[dec_rs2]) ||
                        (dec_rd != 0 && busy_m[dec_rd]));
`endif
        chk("lsu_ready", 32'(lsu_ready), 32'(exp_q.size() < DEPTH));
        chk("alu_hold", 32'(alu_hold), 32'(hold_m));
        chk("stall", 32'(stall), 32'(st_e));
        chk("reg_write", 32'(reg_write), 32'(we_e));
        if (we_e) begin
            chk("rd_addr", 32'(rd_addr), 32'(a_e));
            chk("write_data", write_data, d_e);
        end
        if (log_en && reg_write && !alu_valid) begin
            log_rd.push_back(rd_addr);
            log_data.push_back(write_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    endtask

    task automatic rand_cycle(input int alu_pct);
        logic [4:0] r;
        step();
        alu_valid = !hold_m && ($urandom_range(0, 99) < alu_pct);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
        if (!(lsu_valid && !lsu_acc)) begin
            lsu_valid = 1'b0;
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                lsu_valid = 1'b1;
                lsu_rd    = pend_q.pop_front();
                lsu_data  = $urandom;
            end
        end
        issue_valid = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
            r = 5'($urandom_range(0, 7));
            if (r == 5'd0 || !busy_m[r]) begin
                issue_valid = 1'b1;
                issue_rd    = r;
                pend_q.push_back(r);
            end
        end
        dec_rs1 = 5'($urandom_range(0, 7));
        dec_rs2 = 5'($urandom_range(0, 7));
        dec_rd  = 5'($urandom_range(0, 7));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_alu_hold", 32'(alu_hold), 32'd0);
        step(); rst = 1'b0;

        // ALU-only traffic
        step(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("alu_we", 32'(reg_write), 32'd1);
        chk("alu_rd", 32'(rd_addr), 32'd5);
        chk("alu_data", write_data, 32'hDEADBEEF);
        step(); alu_rd = 5'd0;
        @(negedge clk);
        chk("alu_rd0_we", 32'(reg_write), 32'd0);

        // Load scoreboard
        step(); idle(); issue_valid = 1'b1; issue_rd = 5'd7;
        step(); issue_valid = 1'b0; dec_rs1 = 5'd7;
        @(negedge clk);
        chk("load_stall", 32'(stall), 32'd1);
        step(); lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
        @(negedge clk);
        chk("load_push_we", 32'(reg_write), 32'd0);
        step(); lsu_valid = 1'b0;
        @(negedge clk);
        chk("load_we", 32'(reg_write), 32'd1);
        chk("load_rd", 32'(rd_addr), 32'd7);
        chk("load_data", write_data, 32'h1234);
`ifdef WB_BYPASS_EN
        chk("load_stall_pop", 32'(stall), 32'd0);
        chk("load_byp_hit", 32'(byp_rs1_hit), 32'd1);
        chk("load_byp_data", byp_data, 32'h1234);
`else
        chk("load_stall_pop", 32'(stall), 32'd1);
`endif
        step();
        @(negedge clk);
        chk("load_stall_after", 32'(stall), 32'd0);

        // Backpressure and starvation
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'hA000 + 32'(10 + i);
            @(negedge clk);
            chk("bp_ready", 32'(lsu_ready), 32'd1);
            chk("bp_hold_low", 32'(alu_hold), 32'd0);
            step();
        end
        alu_valid = 1'b0; lsu_rd = 5'd14; lsu_data = 32'hA00E;
        @(negedge clk);
        chk("bp_full", 32'(lsu_ready), 32'd0);
        chk("bp_hold", 32'(alu_hold), 32'd1);
        chk("bp_pop_rd", 32'(rd_addr), 32'd10);
        chk("bp_pop_data", write_data, 32'hA00A);
        step();
        @(negedge clk);
        chk("bp_ready_back", 32'(lsu_ready), 32'd1);
        chk("bp_hold_clear", 32'(alu_hold), 32'd0);
        step(); idle();
        repeat (5) step();

        // Set/clear collision on rd=9
        issue_valid = 1'b1; issue_rd = 5'd9;
        step(); issue_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step(); lsu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        chk("coll_pop_rd", 32'(rd_addr), 32'd9);
        step(); issue_valid = 1'b0; dec_rs1 = 5'd9;
        @(negedge clk);
        chk("coll_busy", 32'(stall), 32'd1);
        step(); dec_rs1 = 5'd0; lsu_valid = 1'b1; lsu_data = 32'h98;
        step(); lsu_valid = 1'b0;
        step(); dec_rs1 = 5'd9;
        @(negedge clk);
        chk("coll_cleared", 32'(stall), 32'd0);

        // Async reset mid-drain with three entries queued
        step(); idle(); issue_valid = 1'b1; issue_rd = 5'd20;
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
            lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'hB000 + 32'(i);
            step();
            issue_valid = 1'b0;
        end
        lsu_valid = 1'b0; dec_rs1 = 5'd20;
        #1;
        chk("mid_stall_pre", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(reg_write), 32'd0);
        chk("mid_rst_ready", 32'(lsu_ready), 32'd1);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_hold", 32'(alu_hold), 32'd0);
        step(); rst = 1'b0; alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_we", 32'(reg_write), 32'd0);
            chk("post_rst_stall", 32'(stall), 32'd0);
            step();
        end

        // Ordering of LSU writes around ALU bubbles
        idle(); log_rd.delete(); log_data.delete(); log_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i);
            step();
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = (c % 2 == 0); alu_rd = 5'd30; alu_data = 32'h3030;
            lsu_valid = (c % 2 == 0); lsu_rd = 5'(c / 2 + 1); lsu_data = 32'h111 * 32'(c / 2 + 1);
            step();
        end
        idle();
        repeat (3) step();
        log_en = 1'b0;
        chk("order_count", 32'(log_rd.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_rd.size(); i++) begin
            chk("order_rd", 32'(log_rd[i]), 32'(i + 1));
            chk("order_data", log_data[i], 32'h111 * 32'(i + 1));
        end

        // Randomized traffic at three ALU pressure levels
        pend_q.delete();
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 1000; n++) rand_cycle(p == 0 ? 30 : (p == 1 ? 70 : 95));
        end
        idle();
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
